// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: valid/ready word load, MSB-first bit stream
// paced by shift_en, with a one-word holding buffer and an optional forced idle gap.
module piso_serializer #(
  parameter int WIDTH    = 4,
  parameter int IDLE_GAP = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             tx_done,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [7:0]       GAP_INIT = 8'(IDLE_GAP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] buf_q;
  logic             buf_full;
  logic [WIDTH-1:0] shifter;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       gap_cnt;

  logic             load_fire;
  logic             strobe;
  logic             word_end;
  logic             reload;
  logic             gap_start;

  assign load_fire = load_valid && !buf_full;
  assign strobe    = (state == SHIFT) && shift_en;
  assign word_end  = strobe && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state; reload moves the buffered word into the shifter.
  always_comb begin
    state_nxt = state;
    reload    = 1'b0;
    gap_start = 1'b0;
    case (state)
      IDLE: begin
        if (buf_full) begin
          reload    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (word_end) begin
          if (IDLE_GAP > 0) begin
            gap_start = 1'b1;
            state_nxt = GAP;
          end else if (buf_full) begin
            reload    = 1'b1;
            state_nxt = SHIFT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt <= 8'd1) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Holding buffer: capture and drain are exclusive because capture needs !buf_full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q    <= '0;
      buf_full <= 1'b0;
    end else if (load_fire) begin
      buf_q    <= load_data;
      buf_full <= 1'b1;
    end else if (reload) begin
      buf_full <= 1'b0;
    end
  end

  // Shifter and bit counter; the counter holds at the last bit instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shifter <= '0;
      bit_cnt <= '0;
    end else if (reload) begin
      shifter <= buf_q;
      bit_cnt <= '0;
    end else if (strobe) begin
      shifter <= {shifter[WIDTH-2:0], 1'b0};
      if (!word_end) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (gap_start) begin
      gap_cnt <= GAP_INIT;
    end else if (state == GAP) begin
      gap_cnt <= gap_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_done <= 1'b0;
    end else begin
      tx_done <= word_end;
    end
  end

  assign load_ready  = !buf_full;
  assign ser_out     = shifter[WIDTH-1];
  assign ser_valid   = (state == SHIFT);
  assign frame_start = (state == SHIFT) && (bit_cnt == '0);
  assign frame_last  = (state == SHIFT) && (bit_cnt == LAST_BIT);
  assign busy        = (state != IDLE) || buf_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one instance with no idle gap, one with IDLE_GAP=2,
// plus a 4-bit shift-in receiver model and a tx_done pulse counter.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       lv = 1'b0, se = 1'b0;
  logic [3:0] ld = '0;
  logic       load_ready, ser_out, ser_valid, frame_start, frame_last, tx_done, busy;

  logic       lv2 = 1'b0, se2 = 1'b0;
  logic [3:0] ld2 = '0;
  logic       load_ready2, ser_out2, ser_valid2, frame_start2, frame_last2, tx_done2, busy2;

  int         total = 0;
  int         bad = 0;

  logic [3:0] rx;
  logic       rx_clr = 1'b0;
  int         txcnt = 0;
  logic       tx_clr = 1'b0;

  piso_serializer #(.WIDTH(4), .IDLE_GAP(0)) u_dut (
    .clk(clk), .reset(reset), .load_valid(lv), .load_ready(load_ready), .load_data(ld),
    .shift_en(se), .ser_out(ser_out), .ser_valid(ser_valid), .frame_start(frame_start),
    .frame_last(frame_last), .tx_done(tx_done), .busy(busy)
  );

  piso_serializer #(.WIDTH(4), .IDLE_GAP(2)) u_dut_gap (
    .clk(clk), .reset(reset), .load_valid(lv2), .load_ready(load_ready2), .load_data(ld2),
    .shift_en(se2), .ser_out(ser_out2), .ser_valid(ser_valid2), .frame_start(frame_start2),
    .frame_last(frame_last2), .tx_done(tx_done2), .busy(busy2)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_clr) rx <= '0;
    else if (ser_valid && se) rx <= {rx[2:0], ser_out};
  end

  always @(negedge clk) begin
    if (tx_clr) txcnt <= 0;
    else if (tx_done) txcnt <= txcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rx_clr = 1'b1;
    tx_clr = 1'b1;
    step();
    rx_clr = 1'b0;
    tx_clr = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ser_out"},    ser_out, 1'b0);
    chk({tag, "_ser_valid"},  ser_valid, 1'b0);
    chk({tag, "_fstart"},     frame_start, 1'b0);
    chk({tag, "_flast"},      frame_last, 1'b0);
    chk({tag, "_tx_done"},    tx_done, 1'b0);
    chk({tag, "_busy"},       busy, 1'b0);
    chk({tag, "_load_ready"}, load_ready, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  w;
    logic [7:0]  seq;
    logic [11:0] expv, expb;
    logic [3:0]  got;
    int          nstb;

    // Reset held from time 0
    #12;
    chk_reset_outputs("init");
    chk("init_gap_ready", load_ready2, 1'b1);
    chk("init_gap_valid", ser_valid2, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clr();

    // Single word 1011, shift_en constant
    w  = 4'b1011;
    lv = 1'b1; ld = w; se = 1'b1;
    step();
    chk("t2_ready_buffered", load_ready, 1'b0);
    chk("t2_busy", busy, 1'b1);
    chk("t2_valid_early", ser_valid, 1'b0);
    lv = 1'b0; ld = '0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", ser_valid, 1'b1);
      chk("t2_bit", ser_out, w[3-i]);
      chk("t2_fstart", frame_start, (i == 0));
      chk("t2_flast", frame_last, (i == 3));
      step();
    end
    chk("t2_tx_done", tx_done, 1'b1);
    chk("t2_valid_end", ser_valid, 1'b0);
    step();
    chk("t2_tx_done_pulse", tx_done, 1'b0);
    chk("t2_txcnt", txcnt, 1);
    chk("t2_rx", rx, 4'b1011);

    // Back-to-back A then 5
    clr();
    seq = 8'b1010_0101;
    lv = 1'b1; ld = 4'hA; se = 1'b1;
    step();
    chk("t3_ready_a", load_ready, 1'b0);
    ld = 4'h5;
    step();
    for (int k = 0; k < 8; k++) begin
      chk("t3_valid", ser_valid, 1'b1);
      chk("t3_bit", ser_out, seq[7-k]);
      chk("t3_fstart", frame_start, (k == 0 || k == 4));
      chk("t3_tx_done", tx_done, (k == 4));
      if (k == 0) chk("t3_ready_drained", load_ready, 1'b1);
      if (k == 1) begin
        chk("t3_ready_5_held", load_ready, 1'b0);
        lv = 1'b0; ld = '0;
      end
      step();
    end
    chk("t3_tx_done2", tx_done, 1'b1);
    chk("t3_valid_end", ser_valid, 1'b0);
    step();
    chk("t3_txcnt", txcnt, 2);
    chk("t3_rx", rx, 4'h5);

    // Word 6, shift_en one cycle in three
    clr();
    w  = 4'h6;
    lv = 1'b1; ld = w; se = 1'b0;
    step();
    lv = 1'b0;
    step();
    got  = '0;
    nstb = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 12) begin
        chk("t4_hold", ser_out, w[3 - c/3]);
        chk("t4_flast", frame_last, (c >= 9));
      end
      se = (c % 3 == 2);
      if (ser_valid && se) begin
        got = {got[2:0], ser_out};
        nstb++;
      end
      if (c == 11) chk("t4_early_done", txcnt, 0);
      step();
    end
    se = 1'b0;
    chk("t4_strobes", nstb, 4);
    chk("t4_bits", got, 4'b0110);
    chk("t4_txcnt", txcnt, 1);
    chk("t4_rx", rx, 4'h6);

    // IDLE_GAP=2 instance: F then 0
    expv = 12'b1111_000_1111_0;
    expb = 12'b1111_000_0000_0;
    lv2 = 1'b1; ld2 = 4'hF; se2 = 1'b1;
    step();
    chk("t5_ready_f", load_ready2, 1'b0);
    ld2 = 4'h0;
    step();
    chk("t5_ready_drained", load_ready2, 1'b1);
    for (int k = 0; k < 12; k++) begin
      if (k == 1) begin
        chk("t5_ready_0_held", load_ready2, 1'b0);
        lv2 = 1'b0;
      end
      chk("t5_valid", ser_valid2, expv[11-k]);
      if (expv[11-k]) chk("t5_bit", ser_out2, expb[11-k]);
      chk("t5_fstart", frame_start2, (k == 0 || k == 7));
      chk("t5_flast", frame_last2, (k == 3 || k == 10));
      chk("t5_tx_done", tx_done2, (k == 4 || k == 11));
      chk("t5_busy", busy2, 1'b1);
      step();
    end
    se2 = 1'b0;

    // Reset mid-word C, then word 3
    clr();
    lv = 1'b1; ld = 4'hC; se = 1'b1;
    step();
    lv = 1'b0;
    step();
    step();
    step();
    chk("t6_pre_reset_bit", ser_out, 1'b0);
    chk("t6_pre_reset_valid", ser_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("t6_async");
    step();
    step();
    chk_reset_outputs("t6_held");
    chk("t6_no_done", txcnt, 0);
    reset = 1'b0;
    w  = 4'h3;
    lv = 1'b1; ld = w;
    step();
    lv = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t6_bit", ser_out, w[3-i]);
      chk("t6_fstart", frame_start, (i == 0));
      chk("t6_tx_early", tx_done, 1'b0);
      step();
    end
    chk("t6_tx_done", tx_done, 1'b1);
    step();
    chk("t6_txcnt", txcnt, 1);
    chk("t6_rx", rx, 4'h3);
    se = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
